// File: rtl/tff_3bits.sv
// Bank of push-button toggle flip-flops with LED readout.
// btn[NUM_TFF] is a synchronous active-high reset. btn[NUM_TFF-1:0] are the toggle
// enables. Level mode toggles on every edge while T is high. Edge mode toggles once
// per 0->1 transition of T.
module tff_3bits #(
  parameter int unsigned NUM_TFF   = 3,
  parameter bit          EDGE_MODE = 1'b0
) (
  input  logic               sysclk,
  input  logic [NUM_TFF:0]   btn,
  output logic [NUM_TFF:0]   led
);

  logic               rst;
  logic [NUM_TFF-1:0] t_in;
  logic [NUM_TFF-1:0] toggle;
  logic [NUM_TFF-1:0] q_d;
  // Power-up value keeps led defined from time 0.
  logic [NUM_TFF-1:0] q_q = '0;

  assign rst  = btn[NUM_TFF];
  assign t_in = btn[NUM_TFF-1:0];

  if (EDGE_MODE) begin : g_edge
    logic [NUM_TFF-1:0] hist_q = '0;

    // History follows the buttons on every edge, reset edges included. A button
    // held through reset therefore produces no false edge afterwards.
    always_ff @(posedge sysclk) begin
      hist_q <= t_in;
    end

    assign toggle = t_in & ~hist_q;
  end else begin : g_level
    assign toggle = t_in;
  end

  // Next state: reset wins over any pending toggle.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = '0;
    end else begin
      q_d = q_q ^ toggle;
    end
  end

  // Flop bank register.
  always_ff @(posedge sysclk) begin
    q_q <= q_d;
  end

  // The LEDs come straight from the flops. The top LED is unused and held low.
  assign led = {1'b0, q_q};

endmodule

// File: tb/tb_tff_3bits.sv
// Bench for tff_3bits. It drives the level-mode and edge-mode instances from the same
// buttons. A reference model checks both instances on every cycle, and directed
// literal expectations pin the model down.
module tb_tff_3bits;

  logic       sysclk = 1'b0;
  logic [3:0] btn    = 4'b0000;
  logic [3:0] led_l;
  logic [3:0] led_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2:0] exp_l  = 3'b000;
  logic [2:0] exp_e  = 3'b000;
  logic [2:0] prev_t = 3'b000;
  bit         chk_en = 1'b1;

  tff_3bits #(.NUM_TFF(3), .EDGE_MODE(1'b0)) dut_l (
    .sysclk (sysclk),
    .btn    (btn),
    .led    (led_l)
  );

  tff_3bits #(.NUM_TFF(3), .EDGE_MODE(1'b1)) dut_e (
    .sysclk (sysclk),
    .btn    (btn),
    .led    (led_e)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Model update at each edge, then compare shortly after the edge.
  always @(posedge sysclk) begin
    logic [3:0] b;
    b = btn;
    if (b[3]) begin
      exp_l = 3'b000;
      exp_e = 3'b000;
    end else begin
      exp_l = exp_l ^ b[2:0];
      exp_e = exp_e ^ (b[2:0] & ~prev_t);
    end
    prev_t = b[2:0];
    #1;
    if (chk_en) begin
      check("model_level", led_l, {1'b0, exp_l});
      check("model_edge", led_e, {1'b0, exp_e});
    end
  end

  // Drive btn at the falling edge, then sample the level instance after the rising edge.
  task automatic step_l(input logic [3:0] b, input logic [3:0] req, input string name);
    @(negedge sysclk);
    btn = b;
    @(posedge sysclk);
    #2;
    check(name, led_l, req);
  endtask

  task automatic step_e(input logic [3:0] b, input logic [3:0] req, input string name);
    @(negedge sysclk);
    btn = b;
    @(posedge sysclk);
    #2;
    check(name, led_e, req);
  endtask

  initial begin
    #1;
    check("power_up_level", led_l, 4'b0000);
    check("power_up_edge", led_e, 4'b0000);

    // Reset behaviour
    for (int i = 0; i < 3; i++) step_l(4'b1111, 4'b0000, "reset_hold");
    check("reset_hold_edge", led_e, 4'b0000);
    for (int i = 0; i < 2; i++) step_l(4'b0000, 4'b0000, "post_reset_idle");

    // Single toggle in level mode
    step_l(4'b0001, 4'b0001, "lvl_single_1");
    step_l(4'b0001, 4'b0000, "lvl_single_2");
    step_l(4'b0001, 4'b0001, "lvl_single_3");
    step_l(4'b0000, 4'b0001, "lvl_single_hold");

    // Independent bits in level mode
    step_l(4'b1000, 4'b0000, "lvl_clear");
    step_l(4'b0010, 4'b0010, "lvl_ind_1");
    step_l(4'b0100, 4'b0110, "lvl_ind_2");
    step_l(4'b0111, 4'b0001, "lvl_ind_3");
    step_l(4'b0111, 4'b0110, "lvl_ind_4");

    // Reset priority over the toggle inputs
    step_l(4'b1111, 4'b0000, "lvl_rst_prio");
    step_l(4'b0011, 4'b0011, "lvl_after_rst");

    // Edge mode
    step_e(4'b1000, 4'b0000, "edge_clear");
    step_e(4'b0000, 4'b0000, "edge_idle");
    step_e(4'b0001, 4'b0001, "edge_hold_1");
    for (int i = 0; i < 3; i++) step_e(4'b0001, 4'b0001, "edge_hold_n");
    step_e(4'b0000, 4'b0001, "edge_release");
    step_e(4'b0001, 4'b0000, "edge_retoggle");
    step_e(4'b1001, 4'b0000, "edge_rst_t_1");
    step_e(4'b1001, 4'b0000, "edge_rst_t_2");
    step_e(4'b0001, 4'b0000, "edge_no_false");
    step_e(4'b0000, 4'b0000, "edge_release2");
    step_e(4'b0101, 4'b0101, "edge_two_bits");

    // Random stimulus; reset asserted about one cycle in 16
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r;
      @(negedge sysclk);
      r = 4'($urandom_range(0, 15));
      r[3] = ($urandom_range(0, 15) == 0);
      btn = r;
    end

    @(negedge sysclk);
    btn = 4'b0000;
    @(posedge sysclk);
    #3;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
